rvvi_tx_frame_arbiter: RTL and testbench
========================================

// Module: rvvi_tx_frame_arbiter
//
// PURPOSE
// Frame-level arbiter sharing the single AXI-stream TX port of the ethernet MAC between two sources:
// S0 = RVVI trace packetizer, S1 = host-control reply frames (acks, rate/slowdown responses).
// Grants whole frames only: beats are never interleaved. A starvation guard protects S0.
// A mid-frame timeout aborts a stalled frame and marks it bad so the MAC FIFO drops it.
//
// PARAMETERS
// MAX_S1_RUN  4     max consecutive S1 frames granted while S0 is waiting (>=1)
// TIMEOUT     4096  cycles of selected-source tvalid low mid-frame before abort; 0 disables
// CNT_WIDTH   16    width of the AbortCount and FrameCount status counters
//
// PORTS
// clk         in   1          logic clock (same as MAC logic_clk)
// reset       in   1          asynchronous, active-high
// S0Tdata     in   32         trace stream data
// S0Tkeep     in   4          trace byte enables
// S0Tvalid    in   1          trace beat valid
// S0Tlast     in   1          trace last beat of frame
// S0Tready    out  1          trace beat accepted
// S1Tdata/S1Tkeep/S1Tvalid/S1Tlast in, S1Tready out: same widths, control stream
// MTdata      out  32         to MAC tx_axis_tdata
// MTkeep      out  4          to MAC tx_axis_tkeep
// MTvalid     out  1          to MAC tx_axis_tvalid
// MTlast      out  1          to MAC tx_axis_tlast
// MTuser      out  1          to MAC tx_axis_tuser; 1 only on the abort beat (bad frame)
// MTready     in   1          from MAC tx_axis_tready
// Grant       out  2          one-hot current owner {S1,S0}; 00 when IDLE/ABORT/FLUSH
// AbortCount  out  CNT_WIDTH  saturating count of aborted frames
// FrameCount  out  CNT_WIDTH  wrapping count of frames completed on M (incl. aborts)
//
// BEHAVIOUR
// Reset (async): state IDLE; all Tready, MTvalid, MTlast, MTuser = 0; Grant = 0; counters = 0.
// States: IDLE, GNT0, GNT1, ABORT, FLUSH. Grant and state are registered.
// IDLE: M outputs idle (MTvalid=0), all Tready=0. Decide on the cycle any Svalid=1:
//  - only S0 valid -> GNT0; only S1 valid -> GNT1.
//  - both valid -> GNT1 unless S1Run == MAX_S1_RUN, then GNT0.
//  First beat can transfer the cycle after entering GNTx (1-cycle arbitration latency).
// S1Run: +1 on each S1 frame end while S0Tvalid=1; cleared on any S0 frame end or S0Tvalid=0
//  at S1 frame end; saturates at MAX_S1_RUN.
// GNTx: zero-latency combinational pass: M{data,keep,valid,last} = Sx; SxTready = MTready;
//  other source Tready = 0; MTuser = 0. Beat transfers when MTvalid & MTready.
//  Transfer with tlast=1 -> IDLE, FrameCount+1. No back-to-back regrant in same cycle.
// Timeout (TIMEOUT>0): StallCnt counts cycles in GNTx with SxTvalid=0, clears on each
//  transfer and on leaving GNTx. At StallCnt == TIMEOUT-1 with SxTvalid=0 -> ABORT.
//  Stalls due to MTready=0 with SxTvalid=1 never count.
// ABORT: MTvalid=1, MTlast=1, MTuser=1, MTdata=0, MTkeep=4'h1; SxTready=0; hold until MTready;
//  on transfer -> FLUSH, AbortCount+1 (saturating), FrameCount+1.
// FLUSH: MTvalid=0; SxTready=1 for the aborted source only; discard beats; on accepted beat
//  with tlast=1 -> IDLE. FLUSH has no timeout (source must eventually end its frame).
// Abort on the very first beat of a grant (no beat ever sent) still emits the abort beat.
// Source must hold data stable while valid & !ready (AXI rule); arbiter never drops an accepted beat.
// Reset mid-frame: M stream truncated without tlast; integrator resets MAC logic domain too.
//
// TESTING
// 1 S0 4-beat frame alone, MTready=1 -> 4 beats on M, last on beat 4, Grant=01, FrameCount=1.
// 2 S0,S1 valid same cycle, MAX_S1_RUN=2, S1 sends 3 frames -> order S1,S1,S0,S1; no interleave.
// 3 S1 requests mid S0 frame -> S1 waits until S0 tlast transfers; S1 beat 1 two cycles later.
// 4 TIMEOUT=8, S0 drops valid after beat 2 -> abort beat (user=1,last=1) 8 cycles later, FLUSH
//   eats S0 rest till tlast, AbortCount=1, then pending S1 granted.
// 5 MTready low 100 cycles with S0Tvalid=1, TIMEOUT=8 -> no abort, data held stable.
// 6 reset asserted in GNT1 mid-frame -> next cycle all readies/MTvalid 0, Grant=00, counters 0.

Source files
------------

// File: rtl/rvvi_tx_frame_arbiter.sv
// rvvi_tx_frame_arbiter
//   Frame-level arbiter that shares the MAC AXI-stream TX port between the
//   RVVI trace packetizer (S0) and host-control reply frames (S1). Whole frames
//   are granted, so beats from different sources are never interleaved. S1 is
//   preferred, but after MAX_S1_RUN consecutive S1 frames with S0 waiting, S0
//   gets the next grant. A frame whose source stops presenting data for
//   TIMEOUT cycles is closed with a bad (tuser=1) last beat, and the rest of
//   that source's frame is then discarded.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   S0T*, S1T*          source streams (data 32, keep 4, valid, last, ready out)
//   MT*                 stream to the MAC (data, keep, valid, last, user, ready in)
//   Grant               registered one-hot owner {S1,S0}; 00 outside GNT0/GNT1
//   AbortCount          saturating count of aborted frames
//   FrameCount          wrapping count of frames closed on M (aborts included)
//   DbgState            current FSM state, for checkers
//
// Handshake: a beat moves on a port in every cycle where its tvalid and tready
// are both 1. A source keeps tdata/tkeep/tlast stable while tvalid=1 and
// tready=0; the arbiter never drops a beat it has acknowledged with tready.
module rvvi_tx_frame_arbiter #(
  parameter int MAX_S1_RUN = 4,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          S0Tdata,
  input  logic [3:0]           S0Tkeep,
  input  logic                 S0Tvalid,
  input  logic                 S0Tlast,
  output logic                 S0Tready,
  input  logic [31:0]          S1Tdata,
  input  logic [3:0]           S1Tkeep,
  input  logic                 S1Tvalid,
  input  logic                 S1Tlast,
  output logic                 S1Tready,
  output logic [31:0]          MTdata,
  output logic [3:0]           MTkeep,
  output logic                 MTvalid,
  output logic                 MTlast,
  output logic                 MTuser,
  input  logic                 MTready,
  output logic [1:0]           Grant,
  output logic [CNT_WIDTH-1:0] AbortCount,
  output logic [CNT_WIDTH-1:0] FrameCount,
  output logic [2:0]           DbgState
);

  localparam int RW = $clog2(MAX_S1_RUN + 1);
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_S1_RUN);
  localparam logic [SW-1:0] STALL_MAX = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GNT0  = 3'd1,
    ST_GNT1  = 3'd2,
    ST_ABORT = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_src;       // granted source, kept through ABORT/FLUSH
  logic [1:0]            r_grant;
  logic [RW-1:0]         r_s1_run;    // consecutive S1 frames while S0 waited
  logic [SW-1:0]         r_stall;     // source-idle cycles inside the current grant
  logic [CNT_WIDTH-1:0]  r_abort_cnt;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;

  logic        w_sel_valid;
  logic        w_sel_last;
  logic [31:0] w_sel_data;
  logic [3:0]  w_sel_keep;
  logic        w_in_gnt;
  logic        w_xfer;
  logic        w_timeout;
  logic        w_pick_s1;

  assign w_sel_valid = r_src ? S1Tvalid : S0Tvalid;
  assign w_sel_last  = r_src ? S1Tlast  : S0Tlast;
  assign w_sel_data  = r_src ? S1Tdata  : S0Tdata;
  assign w_sel_keep  = r_src ? S1Tkeep  : S0Tkeep;
  assign w_in_gnt    = (r_state == ST_GNT0) || (r_state == ST_GNT1);
  assign w_xfer      = w_in_gnt && w_sel_valid && MTready;
  // Only an absent source counts toward the timeout; MAC backpressure never does.
  assign w_timeout   = (TIMEOUT != 0) && w_in_gnt && !w_sel_valid && (r_stall == STALL_MAX);
  // S1 wins unless it has already used its run budget while S0 was waiting.
  assign w_pick_s1   = S1Tvalid && (!S0Tvalid || (r_s1_run != RUN_MAX));

  always_comb begin
    MTdata   = '0;
    MTkeep   = '0;
    MTvalid  = 1'b0;
    MTlast   = 1'b0;
    MTuser   = 1'b0;
    S0Tready = 1'b0;
    S1Tready = 1'b0;
    case (r_state)
      ST_GNT0, ST_GNT1: begin
        MTdata  = w_sel_data;
        MTkeep  = w_sel_keep;
        MTvalid = w_sel_valid;
        MTlast  = w_sel_last;
        if (r_src) S1Tready = MTready;
        else       S0Tready = MTready;
      end
      ST_ABORT: begin
        MTvalid = 1'b1;
        MTlast  = 1'b1;
        MTuser  = 1'b1;
        MTkeep  = 4'h1;
      end
      ST_FLUSH: begin
        if (r_src) S1Tready = 1'b1;
        else       S0Tready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_src       <= 1'b0;
      r_grant     <= 2'b00;
      r_s1_run    <= '0;
      r_stall     <= '0;
      r_abort_cnt <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_stall <= '0;
          if (w_pick_s1) begin
            r_state <= ST_GNT1;
            r_src   <= 1'b1;
            r_grant <= 2'b10;
          end else if (S0Tvalid) begin
            r_state <= ST_GNT0;
            r_src   <= 1'b0;
            r_grant <= 2'b01;
          end
        end
        ST_GNT0, ST_GNT1: begin
          if (w_xfer && w_sel_last) begin
            r_state     <= ST_IDLE;
            r_grant     <= 2'b00;
            r_stall     <= '0;
            r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            if (!r_src || !S0Tvalid)
              r_s1_run <= '0;
            else if (r_s1_run != RUN_MAX)
              r_s1_run <= r_s1_run + RW'(1);
          end else if (w_timeout) begin
            r_state <= ST_ABORT;
            r_grant <= 2'b00;
            r_stall <= '0;
          end else if (w_xfer) begin
            r_stall <= '0;
          end else if (!w_sel_valid) begin
            r_stall <= r_stall + SW'(1);
          end
        end
        ST_ABORT: begin
          if (MTready) begin
            r_state     <= ST_FLUSH;
            r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            if (r_abort_cnt != '1)
              r_abort_cnt <= r_abort_cnt + CNT_WIDTH'(1);
          end
        end
        ST_FLUSH: begin
          // Discard the aborted source's beats until its own frame end.
          if (w_sel_valid && w_sel_last) begin
            r_state <= ST_IDLE;
            if (!r_src) r_s1_run <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Grant      = r_grant;
  assign AbortCount = r_abort_cnt;
  assign FrameCount = r_frame_cnt;
  assign DbgState   = r_state;

endmodule

// File: tb/tb_rvvi_tx_frame_arbiter.sv
// tb_rvvi_tx_frame_arbiter
//   Bench for rvvi_tx_frame_arbiter with MAX_S1_RUN=2, TIMEOUT=8, CNT_WIDTH=16.
//   Source drivers push every offered beat into a per-source expected queue;
//   a monitor logs every beat accepted on M; each scenario task checks the log
//   against the frame-level rules.
module tb_rvvi_tx_frame_arbiter;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   S0Tdata, S1Tdata;
  logic [3:0]    S0Tkeep, S1Tkeep;
  logic          S0Tvalid, S1Tvalid, S0Tlast, S1Tlast;
  logic          S0Tready, S1Tready;
  logic [31:0]   MTdata;
  logic [3:0]    MTkeep;
  logic          MTvalid, MTlast, MTuser, MTready;
  logic [1:0]    Grant;
  logic [CW-1:0] AbortCount, FrameCount;
  logic [2:0]    DbgState;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit drv_kill     = 1'b0;

  logic [35:0] exp_s0_q[$];
  logic [35:0] exp_s1_q[$];
  logic [31:0] m_data_q[$];
  logic [3:0]  m_keep_q[$];
  logic        m_last_q[$];
  logic        m_user_q[$];
  logic [1:0]  m_gnt_q[$];
  int          m_cyc_q[$];

  rvvi_tx_frame_arbiter #(.MAX_S1_RUN(2), .TIMEOUT(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .S0Tdata(S0Tdata), .S0Tkeep(S0Tkeep), .S0Tvalid(S0Tvalid), .S0Tlast(S0Tlast), .S0Tready(S0Tready),
    .S1Tdata(S1Tdata), .S1Tkeep(S1Tkeep), .S1Tvalid(S1Tvalid), .S1Tlast(S1Tlast), .S1Tready(S1Tready),
    .MTdata(MTdata), .MTkeep(MTkeep), .MTvalid(MTvalid), .MTlast(MTlast), .MTuser(MTuser),
    .MTready(MTready), .Grant(Grant), .AbortCount(AbortCount), .FrameCount(FrameCount),
    .DbgState(DbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change at posedge+1, so a handshake seen at negedge is the one
  // that completes at the following posedge.
  always @(negedge clk) begin
    if (!reset && MTvalid && MTready) begin
      m_data_q.push_back(MTdata);
      m_keep_q.push_back(MTkeep);
      m_last_q.push_back(MTlast);
      m_user_q.push_back(MTuser);
      m_gnt_q.push_back(Grant);
      m_cyc_q.push_back(cyc);
    end
  end

  task automatic do_reset();
    reset    = 1'b1;
    S0Tdata  = '0; S0Tkeep = '0; S0Tvalid = 1'b0; S0Tlast = 1'b0;
    S1Tdata  = '0; S1Tkeep = '0; S1Tvalid = 1'b0; S1Tlast = 1'b0;
    MTready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_log();
    exp_s0_q.delete(); exp_s1_q.delete();
    m_data_q.delete(); m_keep_q.delete(); m_last_q.delete();
    m_user_q.delete(); m_gnt_q.delete(); m_cyc_q.delete();
  endtask

  // ---------------- driver ----------------
  // Sends one n-beat frame from source src. After beat index stall_at the
  // source goes idle for stall_len cycles; otherwise gaps are 0..gap_max.
  task automatic send_frame(input bit src, input int n, input int gap_max,
                            input int stall_at, input int stall_len);
    logic [31:0] d;
    logic [3:0]  k;
    logic        rdy;
    int          w;
    int          g;
    for (int b = 0; b < n; b++) begin
      d = $urandom;
      k = 4'($urandom_range(1, 15));
      if (src) begin
        exp_s1_q.push_back({k, d});
        S1Tdata = d; S1Tkeep = k; S1Tlast = (b == n - 1); S1Tvalid = 1'b1;
      end else begin
        exp_s0_q.push_back({k, d});
        S0Tdata = d; S0Tkeep = k; S0Tlast = (b == n - 1); S0Tvalid = 1'b1;
      end
      w = 0;
      do begin
        @(negedge clk);
        w++;
        rdy = src ? S1Tready : S0Tready;
      end while (!rdy && w < 400 && !drv_kill);
      if (drv_kill) begin
        if (src) S1Tvalid = 1'b0; else S0Tvalid = 1'b0;
        return;
      end
      if (!rdy) begin
        tests_run++; tests_failed++;
        $display("FAIL src%0d_handshake: ready never seen in %0d cycles, required ready=1", src, w);
        if (src) S1Tvalid = 1'b0; else S0Tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (src) S1Tvalid = 1'b0; else S0Tvalid = 1'b0;
      g = (b == stall_at) ? stall_len : $urandom_range(0, gap_max);
      if (b != n - 1) repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests_run++;
    if ({S0Tready, S1Tready, MTvalid, MTlast, MTuser} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: got rdy0,rdy1,valid,last,user=%b required 00000",
               {S0Tready, S1Tready, MTvalid, MTlast, MTuser});
    end
    tests_run++;
    if (Grant !== 2'b00) begin
      tests_failed++; $display("FAIL reset_grant: got %b required 00", Grant);
    end
    tests_run++;
    if (AbortCount !== '0 || FrameCount !== '0) begin
      tests_failed++;
      $display("FAIL reset_counters: got abort=%0d frame=%0d required 0/0", AbortCount, FrameCount);
    end
    tests_run++;
    if (DbgState !== 3'd0) begin
      tests_failed++; $display("FAIL reset_dbg_state: got %0d required 0", DbgState);
    end
    do_reset();
  endtask

  task automatic test_s0_single();
    logic [35:0] e;
    do_reset(); clear_log();
    MTready = 1'b1;
    send_frame(1'b0, 4, 0, -1, 0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (m_data_q.size() != 4) begin
      tests_failed++; $display("FAIL s0_single_beats: got %0d beats required 4", m_data_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = exp_s0_q.pop_front();
        tests_run++;
        if ({m_keep_q[i], m_data_q[i]} !== e || m_last_q[i] !== (i == 3) ||
            m_gnt_q[i] !== 2'b01 || m_user_q[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL s0_single_beat%0d: got kd=%h last=%b gnt=%b user=%b required kd=%h last=%b gnt=01 user=0",
                   i, {m_keep_q[i], m_data_q[i]}, m_last_q[i], m_gnt_q[i], m_user_q[i], e, (i == 3));
        end
      end
    end
    tests_run++;
    if (FrameCount !== 16'd1) begin
      tests_failed++; $display("FAIL s0_single_framecount: got %0d required 1", FrameCount);
    end
  endtask

  task automatic test_s1_run_limit();
    int exp_order[4] = '{1, 1, 0, 1};
    int fsrc[$];
    int cur;
    int s;
    logic [35:0] e;
    do_reset(); clear_log();
    MTready = 1'b1;
    fork
      send_frame(1'b0, 2, 0, -1, 0);
      begin
        for (int f = 0; f < 3; f++) send_frame(1'b1, 2, 0, -1, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    cur = -1;
    for (int i = 0; i < m_data_q.size(); i++) begin
      s = (m_gnt_q[i] == 2'b10) ? 1 : ((m_gnt_q[i] == 2'b01) ? 0 : -1);
      if (cur == -1) begin
        fsrc.push_back(s);
        cur = s;
      end
      tests_run++;
      if (s != cur || s == -1) begin
        tests_failed++;
        $display("FAIL s1_run_interleave: beat %0d got src %0d required src %0d", i, s, cur);
      end else begin
        e = (s == 1) ? exp_s1_q.pop_front() : exp_s0_q.pop_front();
        tests_run++;
        if ({m_keep_q[i], m_data_q[i]} !== e) begin
          tests_failed++;
          $display("FAIL s1_run_data: beat %0d got %h required %h", i, {m_keep_q[i], m_data_q[i]}, e);
        end
      end
      if (m_last_q[i]) cur = -1;
    end
    tests_run++;
    if (fsrc.size() != 4) begin
      tests_failed++; $display("FAIL s1_run_frames: got %0d frames required 4", fsrc.size());
    end else begin
      for (int f = 0; f < 4; f++) begin
        tests_run++;
        if (fsrc[f] != exp_order[f]) begin
          tests_failed++;
          $display("FAIL s1_run_order: frame %0d got src %0d required src %0d", f, fsrc[f], exp_order[f]);
        end
      end
    end
  endtask

  task automatic test_s1_mid_s0();
    do_reset(); clear_log();
    MTready = 1'b1;
    fork
      send_frame(1'b0, 6, 0, -1, 0);
      begin
        repeat (3) begin @(posedge clk); #1; end
        send_frame(1'b1, 2, 0, -1, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (m_data_q.size() != 8) begin
      tests_failed++; $display("FAIL mid_beats: got %0d required 8", m_data_q.size());
    end else begin
      tests_run++;
      if (m_gnt_q[0] !== 2'b01 || m_gnt_q[5] !== 2'b01 || !m_last_q[5] ||
          m_gnt_q[6] !== 2'b10 || m_gnt_q[7] !== 2'b10) begin
        tests_failed++;
        $display("FAIL mid_owner: got gnt0=%b gnt5=%b last5=%b gnt6=%b gnt7=%b required 01 01 1 10 10",
                 m_gnt_q[0], m_gnt_q[5], m_last_q[5], m_gnt_q[6], m_gnt_q[7]);
      end
      tests_run++;
      if (m_cyc_q[6] - m_cyc_q[5] != 2) begin
        tests_failed++;
        $display("FAIL mid_latency: got %0d cycles required 2", m_cyc_q[6] - m_cyc_q[5]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset(); clear_log();
    MTready = 1'b1;
    fork
      send_frame(1'b0, 5, 0, 1, 20);
      begin
        repeat (2) begin @(posedge clk); #1; end
        send_frame(1'b1, 2, 0, -1, 0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (m_data_q.size() != 5) begin
      tests_failed++; $display("FAIL timeout_beats: got %0d required 5", m_data_q.size());
    end else begin
      tests_run++;
      if (m_gnt_q[0] !== 2'b01 || m_gnt_q[1] !== 2'b01 || m_user_q[0] || m_user_q[1]) begin
        tests_failed++;
        $display("FAIL timeout_s0_beats: got gnt=%b,%b user=%b,%b required 01,01 0,0",
                 m_gnt_q[0], m_gnt_q[1], m_user_q[0], m_user_q[1]);
      end
      tests_run++;
      if (m_user_q[2] !== 1'b1 || m_last_q[2] !== 1'b1 || m_data_q[2] !== 32'h0 ||
          m_keep_q[2] !== 4'h1 || m_gnt_q[2] !== 2'b00) begin
        tests_failed++;
        $display("FAIL timeout_abort_beat: got user=%b last=%b data=%h keep=%h gnt=%b required 1 1 0 1 00",
                 m_user_q[2], m_last_q[2], m_data_q[2], m_keep_q[2], m_gnt_q[2]);
      end
      tests_run++;
      if (m_cyc_q[2] - m_cyc_q[1] != 9) begin
        tests_failed++;
        $display("FAIL timeout_delay: got %0d cycles after beat 2 required 9", m_cyc_q[2] - m_cyc_q[1]);
      end
      tests_run++;
      if (m_gnt_q[3] !== 2'b10 || m_gnt_q[4] !== 2'b10 || m_last_q[4] !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_s1_after: got gnt=%b,%b last=%b required 10,10 1",
                 m_gnt_q[3], m_gnt_q[4], m_last_q[4]);
      end
    end
    tests_run++;
    if (AbortCount !== 16'd1 || FrameCount !== 16'd2) begin
      tests_failed++;
      $display("FAIL timeout_counters: got abort=%0d frame=%0d required 1/2", AbortCount, FrameCount);
    end
  endtask

  task automatic test_mtready_stall();
    bit held_ok;
    bit saw_grant;
    logic [35:0] first;
    do_reset(); clear_log();
    MTready = 1'b0;
    held_ok = 1'b1;
    saw_grant = 1'b0;
    fork
      send_frame(1'b0, 4, 0, -1, 0);
      begin
        first = exp_s0_q[0];
        for (int w = 0; w < 10 && !saw_grant; w++) begin
          @(negedge clk);
          saw_grant = (Grant === 2'b01);
        end
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (MTvalid !== 1'b1 || {MTkeep, MTdata} !== first || Grant !== 2'b01 || MTuser !== 1'b0)
            held_ok = 1'b0;
        end
        @(posedge clk); #1;
        MTready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (!saw_grant || !held_ok) begin
      tests_failed++;
      $display("FAIL stall_hold: got grant_seen=%b held=%b required 1/1", saw_grant, held_ok);
    end
    tests_run++;
    if (AbortCount !== 16'd0 || m_data_q.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_no_abort: got abort=%0d beats=%0d required 0/4", AbortCount, m_data_q.size());
    end
    tests_run++;
    if (m_data_q.size() > 0 && {m_keep_q[0], m_data_q[0]} !== first) begin
      tests_failed++;
      $display("FAIL stall_first_beat: got %h required %h", {m_keep_q[0], m_data_q[0]}, first);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit got2;
    clear_log();
    MTready = 1'b1;
    got2 = 1'b0;
    fork
      send_frame(1'b1, 6, 0, -1, 0);
      begin
        for (int w = 0; w < 50 && !got2; w++) begin
          @(negedge clk); #1;
          got2 = (m_data_q.size() >= 2);
        end
        @(posedge clk); #1;
        MTready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (Grant !== 2'b10 || FrameCount === 16'd0) begin
          tests_failed++;
          $display("FAIL rst_mid_pre: got grant=%b frames=%0d required 10 and nonzero", Grant, FrameCount);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({S0Tready, S1Tready, MTvalid} !== 3'b000 || Grant !== 2'b00 ||
            AbortCount !== '0 || FrameCount !== '0) begin
          tests_failed++;
          $display("FAIL rst_mid_post: got rdy=%b%b valid=%b grant=%b abort=%0d frame=%0d required 00 0 00 0 0",
                   S0Tready, S1Tready, MTvalid, Grant, AbortCount, FrameCount);
        end
        drv_kill = 1'b1;
      end
    join
    @(posedge clk); #1;
    drv_kill = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit s0_done;
    bit s1_done;
    int cur;
    int s;
    int frames;
    logic [35:0] e;
    do_reset(); clear_log();
    s0_done = 1'b0; s1_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 15; f++) begin
          send_frame(1'b0, $urandom_range(1, 5), 2, -1, 0);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        s0_done = 1'b1;
      end
      begin
        for (int f = 0; f < 15; f++) begin
          send_frame(1'b1, $urandom_range(1, 5), 2, -1, 0);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        s1_done = 1'b1;
      end
      begin
        while (!(s0_done && s1_done)) begin
          @(posedge clk); #1;
          MTready = ($urandom_range(0, 3) != 0);
        end
        MTready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    cur = -1;
    frames = 0;
    for (int i = 0; i < m_data_q.size(); i++) begin
      s = (m_gnt_q[i] == 2'b10) ? 1 : ((m_gnt_q[i] == 2'b01) ? 0 : -1);
      if (cur == -1) cur = s;
      tests_run++;
      if (s == -1 || s != cur || m_user_q[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_owner: beat %0d got src %0d user %b required src %0d user 0",
                 i, s, m_user_q[i], cur);
      end else begin
        if (s == 1) e = (exp_s1_q.size() > 0) ? exp_s1_q.pop_front() : 36'hx;
        else        e = (exp_s0_q.size() > 0) ? exp_s0_q.pop_front() : 36'hx;
        tests_run++;
        if ({m_keep_q[i], m_data_q[i]} !== e) begin
          tests_failed++;
          $display("FAIL rand_data: beat %0d src %0d got %h required %h", i, s, {m_keep_q[i], m_data_q[i]}, e);
        end
      end
      if (m_last_q[i]) begin
        cur = -1;
        frames++;
      end
    end
    tests_run++;
    if (exp_s0_q.size() != 0 || exp_s1_q.size() != 0 || frames != 30) begin
      tests_failed++;
      $display("FAIL rand_complete: got left0=%0d left1=%0d frames=%0d required 0 0 30",
               exp_s0_q.size(), exp_s1_q.size(), frames);
    end
    tests_run++;
    if (FrameCount !== 16'd30 || AbortCount !== 16'd0) begin
      tests_failed++;
      $display("FAIL rand_counters: got frame=%0d abort=%0d required 30/0", FrameCount, AbortCount);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    S0Tdata = '0; S0Tkeep = '0; S0Tvalid = 1'b0; S0Tlast = 1'b0;
    S1Tdata = '0; S1Tkeep = '0; S1Tvalid = 1'b0; S1Tlast = 1'b0;
    MTready = 1'b0;
    test_reset();
    test_s0_single();
    test_s1_run_limit();
    test_s1_mid_s0();
    test_timeout();
    test_mtready_stall();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
